// File: rtl/div_if.sv
// Operand/result bundle for the sequential divider: start/fin handshake plus
// operands and registered results.
interface div_if #(
    parameter int DW = 16,
    parameter int VW = 8
);
    logic          start;
    logic [DW-1:0] A;
    logic [VW-1:0] B;
    logic [DW-1:0] Q;
    logic [VW-1:0] R;
    logic          busy;
    logic          fin;
    logic          dz;

    modport master (output start, A, B, input  Q, R, busy, fin, dz);
    modport slave  (input  start, A, B, output Q, R, busy, fin, dz);
endinterface

// File: rtl/div.sv
// Sequential restoring divider: one quotient bit per clock, MSB first,
// with a start/fin handshake and divide-by-zero flag.
module div #(
    parameter int DW = 16,
    parameter int VW = 8
) (
    input  logic ck,
    input  logic rst_n,
    div_if.slave bus
);
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] ina_q, ina_d;
    logic [VW-1:0] inb_q, inb_d;
    logic [VW-1:0] p_q, p_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] q_q, q_d;
    logic [VW-1:0] r_q, r_d;
    logic          busy_q, busy_d;
    logic          fin_q, fin_d;
    logic          dz_q, dz_d;

    logic [VW:0]   t;
    logic [VW-1:0] diff;
    logic          ge;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ina_q   <= '0;
            inb_q   <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ina_q   <= ina_d;
            inb_q   <= inb_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            fin_q   <= fin_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ina_d   = ina_q;
        inb_d   = inb_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        busy_d  = busy_q;
        fin_d   = 1'b0;
        dz_d    = dz_q;

        // Partial remainder stays below the divisor, so the VW+1-bit compare
        // decides the bit and the low VW bits of the difference are exact.
        t    = {p_q, ina_q[DW-1]};
        ge   = (t >= {1'b0, inb_q});
        diff = t[VW-1:0] - inb_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
            end
            RUN: begin
                ina_d = {ina_q[DW-2:0], 1'b0};
                p_d   = ge ? diff : t[VW-1:0];
                q_d   = {q_q[DW-2:0], ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    r_d     = ge ? diff : t[VW-1:0];
                    state_d = DONE;
                    busy_d  = 1'b0;
                    fin_d   = 1'b1;
                end
            end
            DONE: begin
                // A divide-by-zero lands here with fin still low; it pulses
                // one cycle later so fin follows start by one full cycle.
                if (!fin_q) fin_d = 1'b1;
                else        state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (bus.start) begin
            fin_d = 1'b0;
            if (bus.B != '0) begin
                state_d = RUN;
                ina_d   = bus.A;
                inb_d   = bus.B;
                cnt_d   = '0;
                p_d     = '0;
                busy_d  = 1'b1;
                dz_d    = 1'b0;
            end else begin
                state_d = DONE;
                q_d     = '1;
                r_d     = bus.A[VW-1:0];
                dz_d    = 1'b1;
                busy_d  = 1'b0;
            end
        end
    end

    assign bus.Q    = q_q;
    assign bus.R    = r_q;
    assign bus.busy = busy_q;
    assign bus.fin  = fin_q;
    assign bus.dz   = dz_q;
endmodule

// File: tb/tb_div.sv
// Randomised and directed checks of the sequential divider against a
// plain-arithmetic reference (a/b, a%b, divide-by-zero convention).
module tb_div;
    localparam int DW = 16;
    localparam int VW = 8;

    logic ck = 1'b0;
    logic rst_n = 1'b0;
    always #5 ck = ~ck;

    div_if #(.DW(DW), .VW(VW)) bus();
    div #(.DW(DW), .VW(VW)) dut (.ck(ck), .rst_n(rst_n), .bus(bus));

    int tests = 0;
    int fails = 0;

    task automatic model(input logic [DW-1:0] a, input logic [VW-1:0] b,
                         output logic [DW-1:0] q, output logic [VW-1:0] r,
                         output logic dz, output int lat);
        int unsigned ai, bi;
        ai = a;
        bi = b;
        if (bi == 0) begin
            q = '1; r = a[VW-1:0]; dz = 1'b1; lat = 1;
        end else begin
            q = DW'(ai / bi); r = VW'(ai % bi); dz = 1'b0; lat = DW;
        end
    endtask

    // Leaves the bench at the negedge just after the sampling edge (cycle 0).
    task automatic issue(input logic [DW-1:0] a, input logic [VW-1:0] b);
        @(negedge ck);
        bus.start = 1'b1; bus.A = a; bus.B = b;
        @(negedge ck);
        bus.start = 1'b0;
    endtask

    task automatic wait_fin(output int lat, output int bc);
        lat = 0; bc = 0;
        while (bus.fin !== 1'b1 && lat < 100) begin
            if (bus.busy === 1'b1) bc++;
            @(negedge ck);
            lat++;
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.A = '0; bus.B = '0;
        rst_n = 1'b0;
        #12;
        tests++;
        if ({bus.Q, bus.R, bus.busy, bus.fin, bus.dz} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got Q=%0d R=%0d busy=%b fin=%b dz=%b, want all 0",
                     bus.Q, bus.R, bus.busy, bus.fin, bus.dz);
        end
        @(negedge ck); rst_n = 1'b1;
        repeat (3) @(negedge ck);
        tests++;
        if ({bus.Q, bus.R, bus.busy, bus.fin, bus.dz} !== '0) begin
            fails++;
            $display("FAIL idle_hold: got Q=%0d R=%0d busy=%b fin=%b dz=%b, want all 0",
                     bus.Q, bus.R, bus.busy, bus.fin, bus.dz);
        end
    endtask

    task automatic run_and_check(input string name, input logic [DW-1:0] a, input logic [VW-1:0] b);
        logic [DW-1:0] eq; logic [VW-1:0] er; logic edz; int elat, lat, bc;
        model(a, b, eq, er, edz, elat);
        issue(a, b);
        wait_fin(lat, bc);
        tests++;
        if (lat != elat) begin
            fails++;
            $display("FAIL %s_latency: A=%0d B=%0d got %0d cycles, want %0d", name, a, b, lat, elat);
        end
        tests++;
        if (bus.Q !== eq || bus.R !== er || bus.dz !== edz) begin
            fails++;
            $display("FAIL %s_result: A=%0d B=%0d got Q=%0d R=%0d dz=%b, want Q=%0d R=%0d dz=%b",
                     name, a, b, bus.Q, bus.R, bus.dz, eq, er, edz);
        end
        tests++;
        if (bc != ((b == '0) ? 0 : DW)) begin
            fails++;
            $display("FAIL %s_busy: A=%0d B=%0d busy cycles %0d, want %0d", name, a, b, bc, (b == '0) ? 0 : DW);
        end
        @(negedge ck);
        tests++;
        if (bus.fin !== 1'b0 || bus.Q !== eq || bus.R !== er) begin
            fails++;
            $display("FAIL %s_pulse_hold: fin=%b Q=%0d R=%0d, want fin=0 Q=%0d R=%0d",
                     name, bus.fin, bus.Q, bus.R, eq, er);
        end
    endtask

    task automatic test_directed();
        logic [DW-1:0] av [7] = '{16'd1000, 16'd65535, 16'd3, 16'd255, 16'd5, 16'd9, 16'd0};
        logic [VW-1:0] bv [7] = '{8'd7, 8'd255, 8'd10, 8'd1, 8'd0, 8'd3, 8'd200};
        for (int i = 0; i < 7; i++) run_and_check("directed", av[i], bv[i]);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            logic [DW-1:0] a; logic [VW-1:0] b;
            a = DW'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : VW'($urandom);
            run_and_check("random", a, b);
        end
    endtask

    task automatic test_restart();
        int lat, bc, early;
        early = 0;
        issue(16'd100, 8'd9);
        repeat (3) begin
            @(negedge ck);
            if (bus.fin === 1'b1) early++;
        end
        issue(16'd50, 8'd4);
        wait_fin(lat, bc);
        tests++;
        if (lat != DW || early != 0) begin
            fails++;
            $display("FAIL restart_latency: fin after %0d cycles (early fins %0d), want %0d and 0", lat, early, DW);
        end
        tests++;
        if (bus.Q !== 16'd12 || bus.R !== 8'd2 || bus.dz !== 1'b0) begin
            fails++;
            $display("FAIL restart_result: got Q=%0d R=%0d dz=%b, want Q=12 R=2 dz=0", bus.Q, bus.R, bus.dz);
        end
        @(negedge ck);
    endtask

    task automatic test_reset_midrun();
        int spurious;
        spurious = 0;
        issue(16'd20000, 8'd3);
        repeat (7) @(negedge ck);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.Q, bus.R, bus.busy, bus.fin, bus.dz} !== '0) begin
            fails++;
            $display("FAIL midrun_reset: got Q=%0d R=%0d busy=%b fin=%b dz=%b, want all 0",
                     bus.Q, bus.R, bus.busy, bus.fin, bus.dz);
        end
        repeat (2) @(negedge ck);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge ck);
            if (bus.fin !== 1'b0 || bus.busy !== 1'b0) spurious++;
        end
        tests++;
        if (spurious != 0) begin
            fails++;
            $display("FAIL midrun_no_fin: got %0d cycles with fin/busy high, want 0", spurious);
        end
        run_and_check("after_reset", 16'd20, 8'd6);
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        issue(16'd1000, 8'd7);
        wait_fin(lat, bc);
        tests++;
        if (lat != DW || bus.Q !== 16'd142 || bus.R !== 8'd6) begin
            fails++;
            $display("FAIL b2b_first: lat=%0d Q=%0d R=%0d, want lat=%0d Q=142 R=6", lat, bus.Q, bus.R, DW);
        end
        bus.start = 1'b1; bus.A = 16'd777; bus.B = 8'd13;
        @(negedge ck);
        bus.start = 1'b0;
        tests++;
        if (bus.fin !== 1'b0 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_single_pulse: fin=%b busy=%b, want fin=0 busy=1", bus.fin, bus.busy);
        end
        wait_fin(lat, bc);
        tests++;
        if (lat != DW || bus.Q !== 16'd59 || bus.R !== 8'd10) begin
            fails++;
            $display("FAIL b2b_second: lat=%0d Q=%0d R=%0d, want lat=%0d Q=59 R=10", lat, bus.Q, bus.R, DW);
        end
        @(negedge ck);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_restart();
        test_reset_midrun();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
